// File: rtl/motor_cmd_dispatcher.sv
// ============================================================================
// motor_cmd_dispatcher : 5-byte UART packet parser feeding per-channel step/dir
//                        command queues, plus an on-request status byte burst.
// Revision: 1.0
// ============================================================================
`default_nettype none

module motor_cmd_dispatcher #(
    parameter int NUM_CH  = 10,
    parameter int DIV_W   = 16,
    parameter int STEP_W  = 11,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 262143,
    parameter int GAP     = 4095
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic [NUM_CH-1:0]        ch_active,
    input  logic [NUM_CH-1:0]        term,
    output logic [NUM_CH-1:0]        cmd_valid,
    output logic [NUM_CH*DIV_W-1:0]  cmd_divider,
    output logic [NUM_CH*STEP_W-1:0] cmd_steps,
    output logic [NUM_CH-1:0]        cmd_dir,
    output logic [NUM_CH-1:0]        q_full,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [7:0]               drop_cnt
);

    localparam int ENT_W  = 1 + STEP_W + DIV_W;
    localparam int PW     = $clog2(QDEPTH);
    localparam int CW     = $clog2(QDEPTH + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int GW     = $clog2(GAP + 1);
    localparam int NCHUNK = (NUM_CH + 4) / 5;
    localparam int NB     = 2 * NCHUNK;
    localparam int PADW   = 5 * NCHUNK;
    localparam logic [31:0] FIELD_MASK = 32'(((64'd1 << (DIV_W + STEP_W)) - 64'd1) << 4);
    localparam logic [31:0] USED_MASK  = FIELD_MASK | 32'h8000_0000;

    typedef enum logic [2:0] {P_IDLE, P_PAY0, P_PAY1, P_PAY2, P_PAY3} pstate_t;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} sstate_t;

    pstate_t            r_pstate, w_pstate_nxt;
    logic [3:0]         r_ch;
    logic [23:0]        r_word;
    logic [TW-1:0]      r_tmo;
    logic               w_commit, w_status_req, w_ch_ok, w_drop;
    logic [31:0]        w_word;
    logic [ENT_W-1:0]   w_ent;
    logic [NUM_CH-1:0]  r_act, w_pop, w_push, w_valid, w_full;
    logic [7:0]         r_drop;

    // ---------------- packet parser ----------------
    always_comb begin
        w_pstate_nxt = r_pstate;
        w_commit     = 1'b0;
        w_status_req = 1'b0;
        if (rx_valid) begin
            case (r_pstate)
                P_IDLE: begin
                    if (rx_data[3:0] == 4'hF) w_status_req = 1'b1;
                    else                      w_pstate_nxt = P_PAY0;
                end
                P_PAY0:  w_pstate_nxt = P_PAY1;
                P_PAY1:  w_pstate_nxt = P_PAY2;
                P_PAY2:  w_pstate_nxt = P_PAY3;
                P_PAY3: begin
                    w_pstate_nxt = P_IDLE;
                    w_commit     = 1'b1;
                end
                default: w_pstate_nxt = P_IDLE;
            endcase
        end else if (r_pstate != P_IDLE && r_tmo == '0) begin
            w_pstate_nxt = P_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pstate <= P_IDLE;
            r_ch     <= '0;
            r_word   <= '0;
            r_tmo    <= '0;
        end else begin
            r_pstate <= w_pstate_nxt;
            if (rx_valid)          r_tmo <= TW'(TIMEOUT);
            else if (r_tmo != '0)  r_tmo <= r_tmo - 1'b1;
            if (rx_valid) begin
                if (r_pstate == P_IDLE) r_ch   <= rx_data[3:0];
                else                    r_word <= {rx_data, r_word[23:8]};
            end
        end
    end

    // The final payload byte is still on rx_data when the packet commits.
    assign w_word  = {rx_data, r_word};
    assign w_ent   = {w_word[31], w_word[4+DIV_W +: STEP_W], w_word[4 +: DIV_W]};
    assign w_ch_ok = (r_ch < 4'(NUM_CH));
    assign w_pop   = ch_active & ~r_act & w_valid;
    assign w_drop  = w_commit & ~(|w_push);

    // ---------------- per-channel command queues ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ENT_W-1:0] r_mem [QDEPTH];
        logic [PW-1:0]    r_rd, r_wr;
        logic [CW-1:0]    r_cnt;
        logic [ENT_W-1:0] w_head;

        assign w_valid[c] = (r_cnt != '0);
        assign w_full[c]  = (r_cnt == CW'(QDEPTH));
        assign w_push[c]  = w_commit & w_ch_ok & (r_ch == 4'(c)) & (~w_full[c] | w_pop[c]);
        assign w_head     = r_mem[r_rd];

        always_ff @(posedge CLK) begin
            if (w_push[c]) r_mem[r_wr] <= w_ent;
        end

        always_ff @(posedge CLK) begin
            if (reset) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[c]) r_wr <= r_wr + 1'b1;
                if (w_pop[c])  r_rd <= r_rd + 1'b1;
                if (w_push[c] && !w_pop[c])      r_cnt <= r_cnt + 1'b1;
                else if (!w_push[c] && w_pop[c]) r_cnt <= r_cnt - 1'b1;
            end
        end

        assign cmd_divider[c*DIV_W +: DIV_W]   = w_valid[c] ? w_head[DIV_W-1:0] : '0;
        assign cmd_steps[c*STEP_W +: STEP_W]   = w_valid[c] ? w_head[DIV_W +: STEP_W] : '0;
        assign cmd_dir[c]                      = w_valid[c] & w_head[ENT_W-1];
    end

    assign cmd_valid = w_valid;
    assign q_full    = w_full;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_act  <= '0;
            r_drop <= '0;
        end else begin
            r_act <= ch_active;
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    assign drop_cnt = r_drop;

    // ---------------- status sender ----------------
    sstate_t         r_sstate, w_sstate_nxt;
    logic [2:0]      r_k, w_k_nxt, w_idx;
    logic [GW-1:0]   r_gap, w_gap_nxt;
    logic            r_tx_start, w_tx_start_nxt, w_first_half;
    logic [7:0]      r_tx_data, w_tx_data_nxt;
    logic [PADW-1:0] w_sel, w_shifted;
    logic [4:0]      w_chunk;
    logic            w_unused;

    assign w_first_half = (r_k < 3'(NCHUNK));
    assign w_idx        = w_first_half ? r_k : r_k - 3'(NCHUNK);
    assign w_sel        = w_first_half ? PADW'(w_full) : PADW'(~term);
    assign w_shifted    = w_sel >> ({5'd0, w_idx} * 8'd5);
    assign w_chunk      = w_shifted[4:0];
    assign w_unused     = ^{w_word & ~USED_MASK, w_shifted};

    always_comb begin
        w_sstate_nxt   = r_sstate;
        w_k_nxt        = r_k;
        w_gap_nxt      = r_gap;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        case (r_sstate)
            S_IDLE: begin
                if (w_status_req) begin
                    w_sstate_nxt = S_SEND;
                    w_k_nxt      = 3'd0;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = {r_k, w_chunk};
                    w_gap_nxt      = GW'(GAP);
                    w_sstate_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                // The gap only counts once the transmitter has gone idle again.
                if (tx_busy)               w_gap_nxt = GW'(GAP);
                else if (r_gap != '0)      w_gap_nxt = r_gap - 1'b1;
                else if (r_k == 3'(NB - 1)) w_sstate_nxt = S_IDLE;
                else begin
                    w_sstate_nxt = S_SEND;
                    w_k_nxt      = r_k + 3'd1;
                end
            end
            default: w_sstate_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sstate   <= S_IDLE;
            r_k        <= '0;
            r_gap      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_sstate   <= w_sstate_nxt;
            r_k        <= w_k_nxt;
            r_gap      <= w_gap_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule

`default_nettype wire
